map_query_arbiter: RTL
======================

# map_query_arbiter

Shares the single combinational `map_lut` wall lookup between several requesters: Pac-Man movement, ghost movement and the pellet placer. Each requester posts an (x, y) tile coordinate and waits. The arbiter grants one requester at a time in round-robin order, drives the LUT, and returns the wall bit with a one-cycle response strobe. It sits between the game-logic controllers and the `map_lut` instance, which is then instantiated only here.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).

Ports:
- `clock`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: per-requester lookup request, level, held until served.
- `req_x`  in  8*N_REQ: packed x coordinates; requester i is at bits [8i+7:8i].
- `req_y`  in  7*N_REQ: packed y coordinates; requester i is at bits [7i+6:7i].
- `grant`  out  N_REQ: one-hot, high while requester i's lookup is in flight.
- `rsp_valid`  out  N_REQ: one-hot, one-cycle strobe marking the response for requester i.
- `rsp_wall`  out  1: wall bit (1 = wall); valid when any `rsp_valid` bit is high.
- `map_x`  out  8: coordinate to `map_lut`.
- `map_y`  out  7: coordinate to `map_lut`.
- `map_wall`  in  1: `map_lut` output; combinational from `map_x`/`map_y`.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- States: IDLE, LOOKUP, RESPOND (2-bit encoding).
- IDLE:
  - If any `req` bit is high, pick the winner: the first set bit at or after `rr_ptr`, scanning upward with wrap.
  - Register `grant` (one-hot winner), `map_x`/`map_y` (the winner's coordinates) and the winner index.
  - Go to LOOKUP. With no request, stay in IDLE.
- LOOKUP:
  - `map_x`/`map_y` held stable.
  - Capture `map_wall` into `rsp_wall`.
  - Go to RESPOND.
- RESPOND:
  - `rsp_valid[winner]` = 1 and `grant` cleared.
  - `rr_ptr` = (winner + 1) mod N_REQ.
  - Go to IDLE.
- Coordinates are sampled once, in IDLE. Later changes to `req_x`/`req_y` do not affect the lookup in flight.
- A requester dropping `req` during LOOKUP or RESPOND does not cancel the lookup. The response is still strobed.
- A requester must have `req` low in the cycle after its `rsp_valid`. Otherwise the arbiter treats it as a new request.
- `rsp_wall` holds its value until the next LOOKUP.
- Reset values: state IDLE, `rr_ptr` 0, `grant` 0, `rsp_valid` 0, `rsp_wall` 0, `map_x` 0, `map_y` 0, `busy` 0.

## Timing
- Request seen high in IDLE at cycle t:
  - t+1: LOOKUP, `grant` high.
  - t+2: RESPOND, `rsp_valid` and `rsp_wall` valid.
  - t+3: IDLE, new arbitration.
- Latency is 2 cycles from the sampling edge to `rsp_valid`. Throughput is 1 lookup per 3 cycles.
- The worst-case wait for any requester is N_REQ × 3 cycles + 2.
- Simultaneous requests: exactly one wins per IDLE cycle. The others stay pending; no request is lost.
- Reset asserted mid-lookup aborts it. No `rsp_valid` is produced, and the aborted requester must keep `req` high to be re-served.
- `rr_ptr` wraps from N_REQ−1 to 0.

## Configuration
- `MAP_ARB_BOUNDS_EN` defined:
  - In LOOKUP, if the captured x ≥ 28 or y ≥ 24, `rsp_wall` is forced to 1 regardless of `map_wall`.
  - `map_x`/`map_y` are driven 0 for that lookup.
  - Timing is unchanged.
- Undefined: no range check; `rsp_wall` = `map_wall` for all coordinates.

## Structure
- Package `map_arb_pkg` holds:
  - the state enum constants;
  - `MAP_W` = 28, `MAP_H` = 24;
  - `X_W` = 8, `Y_W` = 7.
- Sub-module `rr_priority_picker`: combinational; `req` and `rr_ptr` in, one-hot winner and index out, `any` flag. It is the only sub-module.

## Test plan
- Single request: requester 0 asks for (14, 18) with `map_lut` returning 1 → `grant[0]` at t+1, `rsp_valid[0]` and `rsp_wall` = 1 at t+2, `busy` low at t+3.
- All four requesting continuously after reset → served in order 0, 1, 2, 3, 0, with one `rsp_valid` every 3 cycles.
- `rr_ptr` = 2 and requests from 0 and 1 → 0 is served, then 1.
- Requester 2 changes `req_x` from 5 to 9 during LOOKUP → `map_x` stays 5 and the response matches tile (5, y).
- Reset asserted in LOOKUP → no `rsp_valid`; all outputs 0 the next cycle; held `req` re-served afterwards.
- With `MAP_ARB_BOUNDS_EN`, request (30, 10) → `rsp_wall` = 1 and `map_x` = 0. Without the macro → `rsp_wall` equals the stub LUT's value.

Source files
------------

// File: rtl/map_arb_pkg.sv
// Shared definitions for the map_lut query arbiter: FSM states, map
// geometry and coordinate widths, plus a map-bounds helper used when the
// MAP_ARB_BOUNDS_EN build option is defined.
package map_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_RESPOND = 2'd2
  } arb_state_e;

  localparam int MAP_W = 28;
  localparam int MAP_H = 24;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;

  // True when (x, y) addresses a tile inside the playfield.
  function automatic logic coord_in_map(input logic [X_W-1:0] x,
                                        input logic [Y_W-1:0] y);
    return (x < X_W'(MAP_W)) && (y < Y_W'(MAP_H));
  endfunction

endpackage : map_arb_pkg

// File: rtl/map_query_arbiter_picker.sv
// Round-robin priority picker: finds the first set request bit at or after
// rr_ptr, scanning upward with wrap-around. Purely combinational.
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any
);

  // Scan N_REQ positions starting at rr_ptr and latch onto the first request.
  always_comb begin
    logic found;
    int   pos;
    found         = 1'b0;
    pos           = 0;
    winner_idx    = '0;
    winner_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end else begin
        pos = pos;
      end
      if (!found && req[pos]) begin
        found      = 1'b1;
        winner_idx = IDX_W'(pos);
      end else begin
        found      = found;
      end
    end
    any = found;
    winner_onehot[winner_idx] = found;
  end

endmodule : rr_priority_picker

// File: rtl/map_query_arbiter.sv
// map_query_arbiter: shares the single combinational map_lut wall lookup
// among N_REQ requesters in round-robin order. One lookup takes three
// cycles (IDLE arbitration, LOOKUP, RESPOND) and ends with a one-cycle
// rsp_valid strobe for the served requester.
// Build option: define MAP_ARB_BOUNDS_EN to force out-of-map coordinates
// to read as walls (map_x/map_y driven 0 for such lookups).
module map_query_arbiter
  import map_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [X_W*N_REQ-1:0] req_x,
  input  logic [Y_W*N_REQ-1:0] req_y,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic                 rsp_wall,
  output logic [X_W-1:0]       map_x,
  output logic [Y_W-1:0]       map_y,
  input  logic                 map_wall,
  output logic                 busy
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               rsp_wall_q, rsp_wall_d;
  logic [X_W-1:0]     map_x_q, map_x_d;
  logic [Y_W-1:0]     map_y_q, map_y_d;
  logic               oob_q, oob_d;

  logic [N_REQ-1:0]   pick_onehot_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic [X_W-1:0]     win_x_s;
  logic [Y_W-1:0]     win_y_s;
  logic [IDX_W-1:0]   rr_next_s;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req           (req),
    .rr_ptr        (rr_ptr_q),
    .winner_onehot (pick_onehot_s),
    .winner_idx    (pick_idx_s),
    .any           (pick_any_s)
  );

  assign win_x_s   = req_x[pick_idx_s*X_W +: X_W];
  assign win_y_s   = req_y[pick_idx_s*Y_W +: Y_W];
  assign rr_next_s = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : (winner_q + IDX_W'(1));

  // Next-state and datapath updates for the IDLE/LOOKUP/RESPOND sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    grant_d     = grant_q;
    rsp_valid_d = '0;
    rsp_wall_d  = rsp_wall_q;
    map_x_d     = map_x_q;
    map_y_d     = map_y_q;
    oob_d       = oob_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
`ifdef MAP_ARB_BOUNDS_EN
          oob_d = !coord_in_map(win_x_s, win_y_s);
`else
          oob_d = 1'b0;
`endif
          grant_d  = pick_onehot_s;
          winner_d = pick_idx_s;
          map_x_d  = oob_d ? '0 : win_x_s;
          map_y_d  = oob_d ? '0 : win_y_s;
          state_d  = ST_LOOKUP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        // Coordinates stay put; the LUT answer is captured on this edge.
        rsp_wall_d  = oob_q ? 1'b1 : map_wall;
        rsp_valid_d = grant_q;
        grant_d     = '0;
        rr_ptr_d    = rr_next_s;
        state_d     = ST_RESPOND;
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any lookup in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_wall_q  <= 1'b0;
      map_x_q     <= '0;
      map_y_q     <= '0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wall_q  <= rsp_wall_d;
      map_x_q     <= map_x_d;
      map_y_q     <= map_y_d;
      oob_q       <= oob_d;
    end
  end

  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wall  = rsp_wall_q;
  assign map_x     = map_x_q;
  assign map_y     = map_y_q;
  assign busy      = (state_q != ST_IDLE);

endmodule : map_query_arbiter
